// File: rtl/mem_sys_pkg.sv
// Shared types and default widths for the memory subsystem request path.
package mem_sys_pkg;

   localparam int unsigned DEF_DATA_WIDTH = 4;
   localparam int unsigned DEF_ADDR_WIDTH = 8;
   localparam int unsigned DEF_LEN_WIDTH  = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2,
      DRAIN = 2'd3
   } state_t;

endpackage

// File: rtl/mem_rd_pipe.sv
// Read-return pipeline: tags each issued read address with valid/last, then
// registers the RAM output two cycles after issue into rd_data/rd_valid/rd_last.
module mem_rd_pipe
   import mem_sys_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  issue,
   input  logic                  issue_last,
   input  logic [DATA_WIDTH-1:0] mem_r_data,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic                  rd_last
);

   logic tag_valid;
   logic tag_last;

   // Stage 1 tracks the address in flight; stage 2 captures the RAM word.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tag_valid <= 1'b0;
         tag_last  <= 1'b0;
         rd_valid  <= 1'b0;
         rd_last   <= 1'b0;
         rd_data   <= '0;
      end else begin
         tag_valid <= issue;
         tag_last  <= issue & issue_last;
         rd_valid  <= tag_valid;
         rd_last   <= tag_last;
         if (tag_valid) begin
            rd_data <= mem_r_data;
         end
      end
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// Request-side initiator for the single-port synchronous RAM: accepts single or
// burst read/write requests, drives the RAM port and returns read beats.
// Optional feature macro: MEM_WRITE_VERIFY_EN (read-back compare of each write
// beat with a sticky err flag); when undefined err is tied low.
module mem_access_ctrl
   import mem_sys_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int unsigned LEN_WIDTH  = DEF_LEN_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [LEN_WIDTH-1:0]  req_len,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  wdata_valid,
   output logic                  wdata_ready,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic                  rd_last,
   output logic                  busy,
   output logic                  err,
   output logic                  mem_wr_en,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_w_data,
   input  logic [DATA_WIDTH-1:0] mem_r_data
);

   state_t                state;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [ADDR_WIDTH-1:0] mem_addr_q;
   logic [DATA_WIDTH-1:0] w_data_q;
   logic [LEN_WIDTH-1:0]  len_q;
   logic [LEN_WIDTH-1:0]  cnt_q;

   logic wr_acc;
   logic rd_issue;
   logic req_acc;
   logic last_beat;

   // The RAM samples its port at the same edge that accepts a beat, so the
   // port is steered from the state register; the hold registers keep the
   // last driven address/data stable between accesses.
   assign wr_acc      = (state == WRITE) && wdata_valid;
   assign rd_issue    = (state == READ);
   assign req_acc     = (state == IDLE) && req_valid;
   assign last_beat   = (cnt_q == len_q);
   assign req_ready   = (state == IDLE);
   assign busy        = (state != IDLE);
   assign wdata_ready = (state == WRITE);
   assign mem_wr_en   = wr_acc;
   assign mem_addr    = (wr_acc || rd_issue) ? addr_q : mem_addr_q;
   assign mem_w_data  = wr_acc ? wdata : w_data_q;

   // Request FSM with burst address/beat counters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         addr_q     <= '0;
         mem_addr_q <= '0;
         w_data_q   <= '0;
         len_q      <= '0;
         cnt_q      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  addr_q <= req_addr;
                  len_q  <= req_len;
                  cnt_q  <= '0;
                  state  <= req_write ? WRITE : READ;
               end
            end
            WRITE: begin
               if (wdata_valid) begin
                  mem_addr_q <= addr_q;
                  w_data_q   <= wdata;
                  addr_q     <= addr_q + ADDR_WIDTH'(1);
                  cnt_q      <= cnt_q + LEN_WIDTH'(1);
                  if (last_beat) begin
                     state <= IDLE;
                  end
               end
            end
            READ: begin
               mem_addr_q <= addr_q;
               addr_q     <= addr_q + ADDR_WIDTH'(1);
               cnt_q      <= cnt_q + LEN_WIDTH'(1);
               if (last_beat) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (rd_valid && rd_last) begin
                  state <= IDLE;
               end
            end
         endcase
      end
   end

   mem_rd_pipe #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_rd_pipe (
      .clk        (clk),
      .reset      (reset),
      .issue      (rd_issue),
      .issue_last (last_beat),
      .mem_r_data (mem_r_data),
      .rd_data    (rd_data),
      .rd_valid   (rd_valid),
      .rd_last    (rd_last)
   );

`ifdef MEM_WRITE_VERIFY_EN
   logic                  vf_pend;
   logic [DATA_WIDTH-1:0] vf_data;
   logic                  err_q;

   // One cycle after a write the RAM shows the just-written word; a new
   // mismatch takes priority over the clear on request accept.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vf_pend <= 1'b0;
         vf_data <= '0;
         err_q   <= 1'b0;
      end else begin
         vf_pend <= wr_acc;
         if (wr_acc) begin
            vf_data <= wdata;
         end
         if (vf_pend && (mem_r_data != vf_data)) begin
            err_q <= 1'b1;
         end else if (req_acc) begin
            err_q <= 1'b0;
         end
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule
